// File: rtl/dcache_ctrl_if.sv
// CPU-side request/response and word-serial memory bus of the data cache.
// The cache itself connects through the slave modport; the driving side uses master.
interface dcache_ctrl_if;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        miss;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] access_cnt;
    logic [31:0] miss_cnt;

    modport slave (
        input  rd_req, wr_req, addr, wr_data, mem_rdata, mem_ack,
        output rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata, access_cnt, miss_cnt
    );

    modport master (
        output rd_req, wr_req, addr, wr_data, mem_rdata, mem_ack,
        input  rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata, access_cnt, miss_cnt
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Stalls the pipeline through miss while a dirty victim is written back and the line refilled.
module dcache_ctrl #(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned SET_ADDR_LEN  = 2,
    parameter int unsigned TAG_ADDR_LEN  = 30 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input logic          clk,
    input logic          rst,
    dcache_ctrl_if.slave bus
);
    localparam int unsigned WORDS = 1 << LINE_ADDR_LEN;
    localparam int unsigned SETS  = 1 << SET_ADDR_LEN;
    localparam logic [LINE_ADDR_LEN:0] LAST_WORD = (LINE_ADDR_LEN + 1)'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StWb, StFill} state_e;

    state_e                   state_q, state_d;
    logic [LINE_ADDR_LEN:0]   cnt_q, cnt_d;
    logic [SETS-1:0]          valid_q, dirty_q;
    logic [TAG_ADDR_LEN-1:0]  tag_q [SETS];
    logic [31:0]              data_q [SETS][WORDS];
    logic [31:0]              access_cnt_q, miss_cnt_q;

    logic [LINE_ADDR_LEN-1:0] offset, word;
    logic [SET_ADDR_LEN-1:0]  set;
    logic [TAG_ADDR_LEN-1:0]  tag;
    logic                     req, write, hit, last;
    logic                     start_miss, fill_we, fill_done;
    logic                     mem_req, mem_we;
    logic [31:0]              mem_addr, mem_wdata;

    assign offset = bus.addr[LINE_ADDR_LEN+1:2];
    assign set    = bus.addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
    assign tag    = bus.addr[31:32-TAG_ADDR_LEN];
    assign word   = cnt_q[LINE_ADDR_LEN-1:0];
    assign req    = bus.rd_req | bus.wr_req;
    assign write  = bus.wr_req;
    assign hit    = (state_q == StIdle) && valid_q[set] && (tag_q[set] == tag);
    assign last   = (cnt_q == LAST_WORD);

    assign bus.rd_data    = hit ? data_q[set][offset] : '0;
    // Held through the whole transfer, and forced low while reset is asserted.
    assign bus.miss       = rst && ((state_q != StIdle) || (req && !hit));
    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.access_cnt = access_cnt_q;
    assign bus.miss_cnt   = miss_cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        start_miss = 1'b0;
        fill_we    = 1'b0;
        fill_done  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state_q)
            StIdle: begin
                if (req && !hit) begin
                    start_miss = 1'b1;
                    cnt_d      = '0;
                    state_d    = (valid_q[set] && dirty_q[set]) ? StWb : StFill;
                end
            end
            StWb: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[set], set, word, 2'b00};
                mem_wdata = data_q[set][word];
                if (bus.mem_ack) begin
                    cnt_d = last ? '0 : cnt_q + 1'b1;
                    if (last) state_d = StFill;
                end
            end
            StFill: begin
                mem_req  = 1'b1;
                mem_addr = {tag, set, word, 2'b00};
                if (bus.mem_ack) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (last) begin
                        fill_done = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            access_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hit && req) access_cnt_q <= access_cnt_q + 32'd1;
            // The line is invalid while being replaced so an abandoned refill never hits.
            if (start_miss) begin
                miss_cnt_q   <= miss_cnt_q + 32'd1;
                valid_q[set] <= 1'b0;
            end
            if (fill_done) begin
                valid_q[set] <= 1'b1;
                dirty_q[set] <= 1'b0;
            end else if (hit && write) begin
                dirty_q[set] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[set][word] <= bus.mem_rdata;
        end else if (hit && write) begin
            data_q[set][offset] <= bus.wr_data;
        end
        if (fill_done) tag_q[set] <= tag;
    end
endmodule
